seq_detector_prog: RTL and testbench
====================================

# seq_detector_prog

Programmable serial bit-pattern detector: successor to the fixed three-state sequence detector, with a runtime-loadable pattern of parametrised length, selectable overlapping/non-overlapping matching, and a saturating detection counter. The counter's low nibble drives the 7-segment display as a hex digit, and the decimal point flashes on each detection. It sits behind the top-level pin wrapper: `ui_in` supplies the serial data and control signals, and `seg` drives `uo_out`.

## Interface
- `PAT_LEN`, 3, pattern length in bits; legal range 2..8.
- `CNT_W`, 4, detection counter width; must be ≥ 4.
- `RESET_PAT`, 3'b011, pattern loaded at reset; width `PAT_LEN`; the MSB is the first bit received.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  reset; asynchronous and active-high.
- `x`  in  1  serial data bit.
- `x_valid`  in  1  sample enable; `x` is consumed only on edges where this is high.
- `pat_load`  in  1  load strobe for `pat_in`.
- `pat_in`  in  `PAT_LEN`  new pattern; MSB is the first bit expected.
- `ovl_mode`  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- `hit`  out  1  registered one-cycle detection pulse.
- `count`  out  `CNT_W`  number of detections; saturates.
- `ovf`  out  1  sticky flag: a detection occurred while `count` was saturated.
- `seg`  out  8  display: `seg[0]`=a … `seg[6]`=g, `seg[7]`=dp; active-high.

## Operation
- Reset values: `pattern`=`RESET_PAT`, `hist`=0, `fill`=0, `hit`=0, `count`=0, `ovf`=0, `seg`=8'h3F (digit "0", dp off).
- `hist[PAT_LEN-1:0]` is a shift register.
- `fill` counts valid bits, saturating at `PAT_LEN`.
- On an accepted sample: `hist_n = {hist[PAT_LEN-2:0], x}` and `fill_n = min(fill+1, PAT_LEN)`.
- `match = x_valid & ~pat_load & (fill_n == PAT_LEN) & (hist_n == pattern)`.
- On match:
  - `hit` ← 1.
  - `count` ← `count`+1, unless `count` is all ones; in that case `count` holds and `ovf` ← 1.
  - Non-overlapping mode: `fill` ← 0, so the next match needs `PAT_LEN` fresh bits.
  - Overlapping mode: `fill` stays at `PAT_LEN`.
- On any edge without a match, `hit` ← 0.
- `pat_load`:
  - When high at an edge: `pattern` ← `pat_in`, `hist` ← 0, `fill` ← 0, `count` ← 0, `ovf` ← 0, `hit` ← 0.
  - It has priority over `x_valid` on the same edge; that sample is discarded.
- `ovl_mode` is sampled every edge. A change affects only matches evaluated from that edge onward.
- `seg[6:0]` is the hex decode of `count[3:0]`, digits 0–F, using standard a–g encodings. `seg[7]` = `hit`.
- `x_valid` low: `hist`, `fill`, `count` and `ovf` hold.

## Timing
- Detection latency: `hit` rises on the same edge that samples the final pattern bit. It is visible for exactly one cycle after that edge.
- `count` and `seg` update on the same edge as `hit`.
- Back-to-back hits (consecutive cycles) are possible only in overlapping mode with periodic patterns, e.g. 11 or 111.
- Reset assertion forces all outputs to their reset values immediately, regardless of `clk`. Deassertion is synchronised externally. The first sample is accepted on the first edge after deassertion.
- `seg` is a combinational function of registered state only, with no input-to-output path.

## Configuration
- Macro: `SEQDET_OVERLAP_EN`.
- Defined: `ovl_mode` behaves as above.
- Undefined: `ovl_mode` is ignored. The block is always non-overlapping (`fill` ← 0 on every match), and the overlap path is not synthesised.

## Structure
- Package `seqdet_pkg`:
  - 7-segment constants: `SEG_HEX[0:15]` and `SEG_DP_BIT` = 7.
  - A `fill` width function: `$clog2(PAT_LEN+1)`.
- Sub-module `seg7_hex_decoder`: combinational, 4-bit input, 7-bit a–g output. It is reusable by other display blocks.
- Top of block: one `always` process for the registers with async reset, plus combinational next-state logic.

## Test plan
- Default pattern 011, non-overlapping, stream 0,1,1,0,1,1 with `x_valid`=1 → `hit` pulses after the 3rd and 6th edges; `count`=2; `seg`=8'h5B.
- Load 101, `ovl_mode`=1, stream 1,0,1,0,1 → hits after edges 3 and 5; `count`=2. With `ovl_mode`=0, same stream → a single hit; `count`=1.
- Pattern 011, stream 0,1 then `x_valid`=0 for 5 cycles, then 1 → exactly one hit, after the final edge; nothing fires in the gap.
- `pat_load` asserted together with `x_valid` on the bit that would complete a match → no `hit`; `count`=0; pattern replaced.
- `CNT_W`=4, force 16 matches → `count`=15 saturated, `ovf`=1; `seg`=8'h71 ("F") with `seg[7]` following `hit`.
- Assert `reset` mid-stream between edges → all outputs return to reset values immediately, `seg`=8'h3F; the pattern returns to `RESET_PAT`.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared constants for the programmable sequence detector: 7-segment encodings
// and the width helper for the valid-bit fill counter.
package seqdet_pkg;

  localparam int unsigned SEG_DP_BIT = 7;

  // a..g in bits 0..6, active-high
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned fill_width(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to 7-segment (a..g) decoder, reusable by any display block.
module seg7_hex_decoder
  import seqdet_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_HEX[digit];
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with saturating hit counter and hex display.
// Define SEQDET_OVERLAP_EN to honour ovl_mode; otherwise matching is always non-overlapping.
module seq_detector_prog
  import seqdet_pkg::*;
#(
  parameter int unsigned          PAT_LEN   = 3,
  parameter int unsigned          CNT_W     = 4,
  parameter logic [PAT_LEN-1:0]   RESET_PAT = 3'b011
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               ovl_mode,
  output logic               hit,
  output logic [CNT_W-1:0]   count,
  output logic               ovf,
  output logic [7:0]         seg
);

  localparam int unsigned        FILL_W    = fill_width(PAT_LEN);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] pattern, pattern_n;
  logic [PAT_LEN-1:0] hist, hist_n, hist_sh;
  logic [FILL_W-1:0]  fill, fill_n, fill_inc;
  logic [CNT_W-1:0]   count_n;
  logic               ovf_n;
  logic               hit_n;
  logic               match;
  logic [6:0]         digit_segs;

`ifndef SEQDET_OVERLAP_EN
  logic unused_ovl_mode;
  assign unused_ovl_mode = ovl_mode;
`endif

  always_comb begin
    pattern_n = pattern;
    hist_n    = hist;
    fill_n    = fill;
    count_n   = count;
    ovf_n     = ovf;
    hit_n     = 1'b0;
    hist_sh   = {hist[PAT_LEN-2:0], x};
    fill_inc  = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    match     = x_valid && !pat_load && (fill_inc == FILL_FULL) && (hist_sh == pattern);

    if (pat_load) begin
      // a sample arriving with the load strobe is dropped
      pattern_n = pat_in;
      hist_n    = '0;
      fill_n    = '0;
      count_n   = '0;
      ovf_n     = 1'b0;
    end else if (x_valid) begin
      hist_n = hist_sh;
      fill_n = fill_inc;
      if (match) begin
        hit_n = 1'b1;
        if (count == '1) begin
          ovf_n = 1'b1;
        end else begin
          count_n = count + CNT_W'(1);
        end
`ifdef SEQDET_OVERLAP_EN
        if (!ovl_mode) begin
          fill_n = '0;
        end
`else
        fill_n = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern <= RESET_PAT;
      hist    <= '0;
      fill    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      hit     <= 1'b0;
    end else begin
      pattern <= pattern_n;
      hist    <= hist_n;
      fill    <= fill_n;
      count   <= count_n;
      ovf     <= ovf_n;
      hit     <= hit_n;
    end
  end

  seg7_hex_decoder u_hex (
    .digit (count[3:0]),
    .segs  (digit_segs)
  );

  always_comb begin
    seg             = '0;
    seg[6:0]        = digit_segs;
    seg[SEG_DP_BIT] = hit;
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: vector table plus saturation and async-reset sequences.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       x, x_valid, pat_load, ovl_mode;
  logic [2:0] pat_in;
  logic       hit, ovf;
  logic [3:0] count;
  logic [7:0] seg;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SEQDET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  localparam logic [6:0] TB_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic       pl;
    logic [2:0] pin;
    logic       ovl;
    logic       xv;
    logic       xb;
    logic       e_hit;
    logic [3:0] e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  seq_detector_prog #(
    .PAT_LEN   (3),
    .CNT_W     (4),
    .RESET_PAT (3'b011)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .x        (x),
    .x_valid  (x_valid),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .ovl_mode (ovl_mode),
    .hit      (hit),
    .count    (count),
    .ovf      (ovf),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  function automatic vec_t mk(logic pl, logic [2:0] pin, logic ovl, logic xv, logic xb,
                              logic e_hit, logic [3:0] e_cnt, logic e_ovf);
    vec_t v;
    v.pl = pl; v.pin = pin; v.ovl = ovl; v.xv = xv; v.xb = xb;
    v.e_hit = e_hit; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_hit, input logic [3:0] e_cnt,
                           input logic e_ovf);
    chk({tag, ".hit"},   {7'd0, hit},   {7'd0, e_hit});
    chk({tag, ".count"}, {4'd0, count}, {4'd0, e_cnt});
    chk({tag, ".ovf"},   {7'd0, ovf},   {7'd0, e_ovf});
    chk({tag, ".seg"},   seg,           {e_hit, TB_HEX[e_cnt]});
  endtask

  task automatic drive(input logic pl, input logic [2:0] pin, input logic ovl,
                       input logic xv, input logic xb);
    @(negedge clk);
    pat_load = pl; pat_in = pin; ovl_mode = ovl; x_valid = xv; x = xb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // pl pin ovl xv x | hit cnt ovf
    // default pattern 011, non-overlapping
    vecs.push_back(mk(0, 3'b000, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 1, 2, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 2, 0));
    // pattern 101 with ovl_mode=1 (overlap only honoured when compiled in)
    vecs.push_back(mk(1, 3'b101, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 3'b000, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 1, 1, 1, OVL, OVL ? 4'd2 : 4'd1, 0));
    // pattern 101, non-overlapping
    vecs.push_back(mk(1, 3'b101, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 0, 1, 0));
    // pattern 011 with a 5-cycle x_valid gap (x held high to tempt a false hit)
    vecs.push_back(mk(1, 3'b011, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 3'b000, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 1, 0));
    // load collides with completing bit: sample dropped, pattern becomes 110
    vecs.push_back(mk(0, 3'b000, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 3'b110, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 1, 0, 1, 0));

    reset = 1'b1; x = 1'b0; x_valid = 1'b0; pat_load = 1'b0; pat_in = 3'b000; ovl_mode = 1'b0;
    #12;
    check_out("reset", 0, 0, 0);
    chk("reset.seg_lit", seg, 8'h3F);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pl, vecs[i].pin, vecs[i].ovl, vecs[i].xv, vecs[i].xb);
      check_out($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_cnt, vecs[i].e_ovf);
      if (i == 6) chk("vec6.seg_lit", seg, 8'h5B);
    end

    // saturation: pattern 111, non-overlapping, 16 matches
    drive(1, 3'b111, 0, 0, 0);
    check_out("sat.load", 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      drive(0, 3'b000, 0, 1, 1);
      drive(0, 3'b000, 0, 1, 1);
      drive(0, 3'b000, 0, 1, 1);
      if (k >= 15)
        check_out($sformatf("sat%0d", k), 1, 4'hF, (k == 16));
      else if (k == 8)
        check_out("sat8", 1, 4'd8, 0);
    end
    chk("sat.seg_hit_lit", seg, 8'hF1);
    drive(0, 3'b000, 0, 0, 0);
    check_out("sat.idle", 0, 4'hF, 1);
    chk("sat.seg_idle_lit", seg, 8'h71);

    // async reset between edges, mid-stream
    drive(0, 3'b000, 0, 1, 1);
    check_out("pre_rst", 0, 4'hF, 1);
    #3;
    reset = 1'b1;
    #1;
    check_out("async_rst", 0, 0, 0);
    chk("async_rst.seg_lit", seg, 8'h3F);
    @(posedge clk);
    #1;
    check_out("rst_held", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 3'b000, 0, 1, 0);
    check_out("post_rst0", 0, 0, 0);
    drive(0, 3'b000, 0, 1, 1);
    check_out("post_rst1", 0, 0, 0);
    drive(0, 3'b000, 0, 1, 1);
    check_out("post_rst2", 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
